// File: rtl/ram_block_reader.sv
// ---------------------------------------------------------------------------
// ram_block_reader
//
// Read-side initiator for one port of a single-clock RAM with a 1-cycle
// registered read. A start command reads `length` consecutive words from
// `base_addr` (wrapping modulo DEPTH) and streams them out on a valid/ready
// interface. A 2-entry output FIFO absorbs the RAM read latency, so reads
// are only issued when there is guaranteed room for the returning word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command strobe, sampled only in IDLE
//   base_addr [AW]      first word address, captured with start
//   length    [AW+1]    word count (0..DEPTH), captured with start
//   busy                high while the command is running
//   done                one-cycle pulse after the last word is accepted
//   ram_en, ram_addr    RAM read strobe and address
//   ram_dout  [WIDTH]   RAM read data, valid the cycle after ram_en
//   m_valid, m_data     output stream (registered, driven from FIFO head)
//   m_ready             output stream consumer ready
// ---------------------------------------------------------------------------
module ram_block_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic             ram_en,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [AW:0]      len_q;      // words requested by the current command
  logic [AW:0]      issued;     // RAM reads issued so far
  logic [AW:0]      accepted;   // stream handshakes completed so far
  logic             inflight;   // a read was issued last cycle; data arrives now
  logic [1:0]       occ;        // FIFO occupancy (0..2)
  logic [WIDTH-1:0] tail;       // second FIFO entry; the head is m_data itself
  logic [1:0]       occ_next;

  logic             pop;
  logic             push;
  logic             space_ok;
  logic             last_pop;
  logic [AW-1:0]    addr_inc;

  assign pop  = m_valid & m_ready;
  assign push = inflight;

  // A read may issue only if the word it returns will find a free slot:
  // entries held plus the read still in flight, minus the word leaving now,
  // must be below the FIFO depth. Written as a sum to avoid underflow.
  assign space_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // NOTE: ram_en is combinational so a pop in this cycle frees a slot for an
  // issue in the same cycle; that is what sustains one word per cycle.
  assign ram_en = (state == S_RUN) && (issued < len_q) && space_ok;

  assign last_pop = pop && (accepted == len_q - 1'b1);

  // Explicit wrap keeps non-power-of-two depths correct.
  assign addr_inc = (ram_addr == AW'(DEPTH - 1)) ? '0 : ram_addr + 1'b1;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + 2'd1;
    end else if (!push && pop) begin
      occ_next = occ - 2'd1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order. The
  // two FIFO data entries are reset too: they are tiny, and m_data must read
  // zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_addr <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      occ      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      tail     <= '0;
    end else begin
      // Read pipeline and output FIFO.
      inflight <= ram_en;
      occ      <= occ_next;
      m_valid  <= (occ_next != 2'd0);

      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) m_data <= ram_dout;
          else             tail   <= ram_dout;
        end
        2'b01: begin
          // Advance the tail into the head; if the FIFO empties, the head
          // keeps a stale value that is masked by m_valid=0.
          m_data <= tail;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            m_data <= ram_dout;
          end else begin
            m_data <= tail;
            tail   <= ram_dout;
          end
        end
        default: ;
      endcase

      // Control FSM.
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= length;
            ram_addr <= base_addr;
            issued   <= '0;
            accepted <= '0;
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ram_en) begin
            issued   <= issued + 1'b1;
            ram_addr <= addr_inc;
          end
          if (pop) begin
            accepted <= accepted + 1'b1;
          end
          if (last_pop) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_block_reader
//
// Self-checking bench for ram_block_reader. A behavioural RAM (mem[i]=i,
// 1-cycle registered read) feeds the DUT. Each command pushes its expected
// addresses and words onto queues; a negedge monitor pops and compares them
// as reads are issued and words are accepted, and checks stream stability
// and the outstanding-read bound.
// ---------------------------------------------------------------------------
module tb_ram_block_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      length;
  logic             busy;
  logic             done;
  logic             ram_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  ram_block_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
  end
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  // Scoreboard and counters.
  logic [AW-1:0]    addr_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit cmd_nonzero = 1'b0;
  int pops_total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  // Monitor: samples at negedge, i.e. the values the next rising edge sees.
  int               outstanding;
  bit               prev_valid;
  bit               prev_ready;
  bit               pop_prev;
  bit               mon_pop;
  logic [WIDTH-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
      pop_prev    = 1'b0;
    end else begin
      mon_pop = m_valid && m_ready;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      check("spurious_ram_en", ram_en && addr_q.size() == 0, 0);
      if (ram_en && addr_q.size() != 0) check("ram_addr", ram_addr, addr_q.pop_front());
      check("extra_word", mon_pop && exp_q.size() == 0, 0);
      if (mon_pop && exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
      check("occupancy_le2", outstanding <= 2, 1);
      if (done && cmd_nonzero) check("done_after_last", pop_prev, 1);
      check("done_excl_busy", done && busy, 0);
      outstanding = outstanding + int'(ram_en) - int'(mon_pop);
      prev_valid  = m_valid;
      prev_ready  = m_ready;
      prev_data   = m_data;
      pop_prev    = mon_pop;
      pops_total  = pops_total + int'(mon_pop);
    end
  end

  // One command, driven to completion. pct is the m_ready probability; poke
  // raises start mid-run, which the DUT must ignore.
  task automatic run_cmd(input int base, input int len, input int pct, input bit poke);
    int cyc;
    bit got_done;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    m_ready   = rdy(pct);
    for (int k = 0; k < len; k++) begin
      addr_q.push_back(AW'((base + k) % DEPTH));
      exp_q.push_back(mem[(base + k) % DEPTH]);
    end
    cmd_nonzero = (len != 0);
    @(posedge clk); #1;
    start   = 1'b0;
    m_ready = rdy(pct);
    cyc      = 0;
    got_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_in_run", busy, len != 0);
        check("first_ram_en", ram_en, len != 0);
      end
      if (cyc == 1) check("m_valid_after_e1", m_valid, 0);
      if (cyc == 2) check("m_valid_after_e2", m_valid, 1);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (cyc >= 20 * len + 100) break;
      cyc++;
      @(posedge clk); #1;
      m_ready = rdy(pct);
      if (poke) begin
        start     = (cyc == 3);
        base_addr = AW'($urandom_range(DEPTH - 1, 0));
        length    = (AW+1)'(3);
      end
    end
    check("done_seen", got_done, 1);
    if (pct == 100) check("cycles_to_done", cyc, (len == 0) ? 0 : len + 2);
    check("words_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    cmd_nonzero = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int guard;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, ram_en, m_valid}, 4'b0000);
    check("reset_data", m_data, 0);
    check("reset_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with start low for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {busy, done, ram_en, m_valid}, 4'b0000);
    end

    // Basic burst, wrap, backpressure, zero length, full depth.
    run_cmd(10, 5, 100, 1'b0);
    run_cmd(254, 4, 100, 1'b0);
    run_cmd(20, 8, 30, 1'b1);
    run_cmd(250, 12, 50, 1'b0);
    run_cmd(5, 0, 100, 1'b0);
    run_cmd(77, DEPTH, 100, 1'b0);

    // Reset mid-burst after 3 of 10 words.
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(100);
    length    = (AW+1)'(10);
    m_ready   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      addr_q.push_back(AW'(100 + k));
      exp_q.push_back(mem[100 + k]);
    end
    cmd_nonzero = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0    = pops_total;
    guard = 0;
    while (pops_total - p0 < 3 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check("mid_reset_reached", pops_total - p0 >= 3, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    cmd_nonzero = 1'b0;
    #1;
    check("async_reset_ctrl", {busy, done, ram_en, m_valid}, 4'b0000);
    check("async_reset_data", m_data, 0);
    check("async_reset_addr", ram_addr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("quiet_after_abort", {busy, done, ram_en, m_valid}, 4'b0000);
    end
    run_cmd(0, 2, 100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
